// File: rtl/logs_note_seq_if.sv
// Handshake/config bundle between the register logic, the note sequencer and the NCO.
interface logs_note_seq_if #(
   parameter int unsigned N     = 5,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned DUR_W = 6
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned FW = N - 1;

   logic          step;
   logic          start;
   logic          stop;
   logic          loop;
   logic [AW-1:0] last_idx;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [FW-1:0] wr_freq;
   logic [DUR_W-1:0] wr_dur;
   logic [FW-1:0] nco_freq;
   logic          nco_step;
   logic          busy;
   logic [AW-1:0] note_idx;
   logic          done;

   // Config/control side.
   modport master (
      output step, start, stop, loop, last_idx, wr_en, wr_addr, wr_freq, wr_dur,
      input  nco_freq, nco_step, busy, note_idx, done
   );

   // Sequencer side.
   modport slave (
      input  step, start, stop, loop, last_idx, wr_en, wr_addr, wr_freq, wr_dur,
      output nco_freq, nco_step, busy, note_idx, done
   );
endinterface

// File: rtl/logs_note_seq.sv
// Note sequencer: plays a small {freq, dur} table into the square-wave NCO,
// inserting a silent articulation gap between notes, once or looping.
module logs_note_seq #(
   parameter int unsigned N         = 5,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned DUR_W     = 6,
   parameter int unsigned GAP_TICKS = 1
) (
   input logic              clk,
   input logic              rst_n,
   logs_note_seq_if.slave   bus
);
   localparam int unsigned AW       = $clog2(DEPTH);
   localparam int unsigned FW       = N - 1;
   localparam int unsigned GW       = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
   localparam int unsigned GAP_LOAD = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;
   localparam bit          HAS_GAP  = (GAP_TICKS != 0);

   typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

   state_t           state;
   logic [DUR_W-1:0] dur_cnt;
   logic [GW-1:0]    gap_cnt;
   logic [FW-1:0]    nco_freq;
   logic [AW-1:0]    note_idx;
   logic             busy;
   logic             done;

   logic [FW-1:0]    freq_tbl [DEPTH];
   logic [DUR_W-1:0] dur_tbl  [DEPTH];

   logic             adv_c;
   logic             last_c;
   logic [AW-1:0]    nxt_idx_c;

   // Note table: writable at any time, never reset.
   always_ff @(posedge clk) begin
      if (bus.wr_en) begin
         freq_tbl[bus.wr_addr] <= bus.wr_freq;
         dur_tbl[bus.wr_addr]  <= bus.wr_dur;
      end
   end

   // Advance request: a note ending with no gap, or the last gap tick.
   always_comb begin
      adv_c = 1'b0;
      if (bus.step) begin
         if (state == NOTE && dur_cnt == '0 && !HAS_GAP) adv_c = 1'b1;
         if (state == GAP && gap_cnt == '0)              adv_c = 1'b1;
      end
   end

   // Next entry: step forward (wrapping) until last_idx, then back to 0.
   always_comb begin
      last_c    = (note_idx == bus.last_idx);
      nxt_idx_c = last_c ? '0 : AW'(note_idx + 1'b1);
   end

   // Playback FSM with registered outputs; stop overrides all but reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         dur_cnt  <= '0;
         gap_cnt  <= '0;
         nco_freq <= '0;
         note_idx <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (bus.stop) begin
            state    <= IDLE;
            nco_freq <= '0;
            busy     <= 1'b0;
         end else if (adv_c) begin
            if (last_c && !bus.loop) begin
               state    <= IDLE;
               nco_freq <= '0;
               busy     <= 1'b0;
               done     <= 1'b1;
            end else begin
               state    <= NOTE;
               note_idx <= nxt_idx_c;
               nco_freq <= freq_tbl[nxt_idx_c];
               dur_cnt  <= dur_tbl[nxt_idx_c];
            end
         end else begin
            case (state)
               IDLE: begin
                  if (bus.start) begin
                     state    <= NOTE;
                     note_idx <= '0;
                     nco_freq <= freq_tbl[0];
                     dur_cnt  <= dur_tbl[0];
                     busy     <= 1'b1;
                  end
               end
               NOTE: begin
                  if (bus.step) begin
                     if (dur_cnt == '0) begin
                        state    <= GAP;
                        gap_cnt  <= GW'(GAP_LOAD);
                        nco_freq <= '0;
                     end else begin
                        dur_cnt <= DUR_W'(dur_cnt - 1'b1);
                     end
                  end
               end
               GAP: begin
                  if (bus.step) gap_cnt <= GW'(gap_cnt - 1'b1);
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Step gate stays combinational so it lines up with the NCO tick.
   assign bus.nco_step = bus.step & (state == NOTE);
   assign bus.nco_freq = nco_freq;
   assign bus.note_idx = note_idx;
   assign bus.busy     = busy;
   assign bus.done     = done;
endmodule

// File: tb/tb_logs_note_seq.sv
// Directed bench for logs_note_seq: a per-cycle vector table for one-shot
// playback plus hand-written sequences for loop, stop, rewrite and reset.
module tb_logs_note_seq;
   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   logs_note_seq_if #(.N(5), .DEPTH(8), .DUR_W(6)) bus ();

   logs_note_seq #(.N(5), .DEPTH(8), .DUR_W(6), .GAP_TICKS(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic step;
      logic start;
      logic stop;
      logic loop;
      int   e_freq;
      int   e_nstep;
      int   e_busy;
      int   e_idx;
      int   e_done;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change at negedge; outputs are sampled 1 time unit later.
   task automatic cyc(input logic st, input logic sr, input logic sp);
      @(negedge clk);
      bus.step  = st;
      bus.start = sr;
      bus.stop  = sp;
      #1;
   endtask

   task automatic wr(input int addr, input int freq, input int dur);
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_addr = 3'(addr);
      bus.wr_freq = 4'(freq);
      bus.wr_dur  = 6'(dur);
      @(negedge clk);
      bus.wr_en   = 1'b0;
   endtask

   task automatic add(input logic st, input logic sr, input int f, input int ns,
                      input int b, input int ix, input int d);
      vec_t v;
      v.step = st; v.start = sr; v.stop = 1'b0; v.loop = 1'b0;
      v.e_freq = f; v.e_nstep = ns; v.e_busy = b; v.e_idx = ix; v.e_done = d;
      vecs.push_back(v);
   endtask

   task automatic chk_all(input string tag, input int f, input int ns, input int b,
                          input int ix, input int d);
      chk({tag, "_freq"},  int'(bus.nco_freq), f);
      chk({tag, "_nstep"}, int'(bus.nco_step), ns);
      chk({tag, "_busy"},  int'(bus.busy), b);
      chk({tag, "_idx"},   int'(bus.note_idx), ix);
      chk({tag, "_done"},  int'(bus.done), d);
   endtask

   initial begin
      int exp_f [7];
      int exp_s [7];
      int exp_b [7];
      int exp_i [7];
      int exp_d [7];
      n_chk = 0; n_fail = 0;
      rst_n = 1'b0;
      bus.step = 0; bus.start = 0; bus.stop = 0; bus.loop = 0;
      bus.last_idx = 3'd1; bus.wr_en = 0; bus.wr_addr = '0; bus.wr_freq = '0; bus.wr_dur = '0;

      // One-shot, step every 4th cycle: row = inputs this cycle, outputs seen this cycle.
      add(0,1, 0,0,0,0,0);
      add(1,0, 3,1,1,0,0); add(0,0, 3,0,1,0,0); add(0,0, 3,0,1,0,0); add(0,0, 3,0,1,0,0);
      add(1,0, 3,1,1,0,0); add(0,0, 3,0,1,0,0); add(0,0, 3,0,1,0,0); add(0,0, 3,0,1,0,0);
      add(1,0, 3,1,1,0,0); add(0,0, 0,0,1,0,0); add(0,0, 0,0,1,0,0); add(0,0, 0,0,1,0,0);
      add(1,0, 0,0,1,0,0); add(0,0, 7,0,1,1,0); add(0,0, 7,0,1,1,0); add(0,0, 7,0,1,1,0);
      add(1,0, 7,1,1,1,0); add(0,0, 0,0,1,1,0); add(0,0, 0,0,1,1,0); add(0,0, 0,0,1,1,0);
      add(1,0, 0,0,1,1,0); add(0,0, 0,0,0,1,1); add(0,0, 0,0,0,1,0);

      // Reset and idle
      cyc(0,0,0); cyc(0,0,0);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cyc(1,0,0);
         chk_all("idle", 0, 0, 0, 0, 0);
      end

      wr(0, 3, 2);
      wr(1, 7, 0);

      foreach (vecs[i]) begin
         @(negedge clk);
         bus.step = vecs[i].step; bus.start = vecs[i].start;
         bus.stop = vecs[i].stop; bus.loop = vecs[i].loop;
         #1;
         chk_all($sformatf("oneshot%0d", i), vecs[i].e_freq, vecs[i].e_nstep,
                 vecs[i].e_busy, vecs[i].e_idx, vecs[i].e_done);
      end

      // Loop wrap, step every cycle: 4 cycles on entry 0, 2 on entry 1
      bus.loop = 1'b1;
      cyc(0,1,0);
      for (int k = 1; k <= 10; k++) begin
         cyc(1,0,0);
         chk("loop_idx",  int'(bus.note_idx), (((k - 1) % 6) < 4) ? 0 : 1);
         chk("loop_busy", int'(bus.busy), 1);
         chk("loop_done", int'(bus.done), 0);
      end
      bus.loop = 1'b0;
      cyc(1,0,0); chk("unloop_idx", int'(bus.note_idx), 1);
      cyc(1,0,0); chk("unloop_gap_freq", int'(bus.nco_freq), 0);
      cyc(0,0,0); chk_all("unloop_end", 0, 0, 0, 1, 1);
      cyc(0,0,0); chk("unloop_done_clr", int'(bus.done), 0);

      // Stop mid-note on entry 0, tick 2
      cyc(0,1,0);
      cyc(1,0,0); cyc(1,0,0);
      cyc(1,0,1); chk_all("stop_pre", 3, 1, 1, 0, 0);
      cyc(1,0,0); chk_all("stop_post", 0, 0, 0, 0, 0);
      cyc(1,1,1); chk("startstop_busy", int'(bus.busy), 0);
      cyc(1,0,0); chk_all("startstop_idle", 0, 0, 0, 0, 0);

      // Rewrite entry 0 while it plays
      bus.loop = 1'b1;
      cyc(0,1,0);
      cyc(1,0,0);
      bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_freq = 4'd5; bus.wr_dur = 6'd2;
      cyc(1,0,0); bus.wr_en = 1'b0;
      chk("wr_cur_freq", int'(bus.nco_freq), 3);
      cyc(1,0,0); chk("wr_cur_freq2", int'(bus.nco_freq), 3);
      cyc(1,0,0); cyc(1,0,0); cyc(1,0,0); cyc(1,0,0);
      chk("wr_next_idx", int'(bus.note_idx), 0);
      chk("wr_next_freq", int'(bus.nco_freq), 5);
      cyc(1,0,1);
      cyc(0,0,0); chk("wr_stop_busy", int'(bus.busy), 0);
      bus.loop = 1'b0;
      wr(0, 3, 2);

      // Sync reset during GAP, then replay
      cyc(0,1,0);
      cyc(1,0,0); cyc(1,0,0); cyc(1,0,0);
      cyc(1,0,0); chk_all("rst_gap", 0, 0, 1, 0, 0);
      rst_n = 1'b0;
      cyc(1,0,0); rst_n = 1'b1;
      chk_all("rst_after", 0, 0, 0, 0, 0);
      exp_f = '{3, 3, 3, 0, 7, 0, 0};
      exp_s = '{1, 1, 1, 0, 1, 0, 0};
      exp_b = '{1, 1, 1, 1, 1, 1, 0};
      exp_i = '{0, 0, 0, 0, 1, 1, 1};
      exp_d = '{0, 0, 0, 0, 0, 0, 1};
      cyc(0,1,0);
      for (int k = 0; k < 7; k++) begin
         cyc(1,0,0);
         chk_all($sformatf("replay%0d", k), exp_f[k], exp_s[k], exp_b[k], exp_i[k], exp_d[k]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
